// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised register file with one write port and NREAD
// independent registered read ports. Storage is flop-based with synchronous
// clear, one index is hardwired to zero, and a same-cycle write can optionally
// be forwarded to reads of the same index. Each read port holds its last data
// while idle and flags every accepted read with a one-cycle valid pulse.
module regfile_multiport #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = DEPTH - 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        RegWrite,
  input  logic [AW-1:0]               WriteRegister,
  input  logic [WIDTH-1:0]            WriteData,
  input  logic [NREAD-1:0]            ReadEn,
  input  logic [NREAD-1:0][AW-1:0]    ReadRegister,
  output logic [NREAD-1:0][WIDTH-1:0] ReadData,
  output logic [NREAD-1:0]            ReadValid
);

  // Index constants at index width; the depth limit carries one extra bit so
  // a power-of-two DEPTH does not truncate to zero.
  localparam logic [AW-1:0] ZERO_IDX  = AW'(ZERO_REG);
  localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] entry [DEPTH];
  logic             write_ok;

  // A write lands only for a real, in-range, non-zero register.
  assign write_ok = RegWrite && (WriteRegister != ZERO_IDX) &&
                    ({1'b0, WriteRegister} < DEPTH_LIM);

  genvar gi;

  // One flop bank per register; each bank owns its own enable decode.
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] value_reg;

    // Clear on reset, otherwise capture WriteData when addressed.
    always_ff @(posedge clk) begin
      if (reset) begin
        value_reg <= '0;
      end else if (write_ok && (WriteRegister == AW'(gi))) begin
        value_reg <= WriteData;
      end
    end

    assign entry[gi] = value_reg;
  end

  // Each read port resolves its own source and owns its output registers.
  for (gi = 0; gi < NREAD; gi++) begin : g_port
    logic [AW-1:0]    idx;
    logic             in_range;
    logic             is_zero;
    logic             bypass_hit;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    assign idx        = ReadRegister[gi];
    assign in_range   = ({1'b0, idx} < DEPTH_LIM);
    assign is_zero    = (idx == ZERO_IDX);
    assign bypass_hit = (BYPASS != 0) && RegWrite && (WriteRegister == idx);

    // Source priority: zero/out-of-range, then forwarded write, then storage.
    always_comb begin
      data_next = '0;
      if (in_range && !is_zero) begin
        if (bypass_hit) begin
          data_next = WriteData;
        end else begin
          data_next = entry[idx];
        end
      end
    end

    // Register the read; idle cycles drop valid and keep the last data.
    always_ff @(posedge clk) begin
      if (reset) begin
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= ReadEn[gi];
        if (ReadEn[gi]) begin
          data_reg <= data_next;
        end
      end
    end

    assign ReadData[gi]  = data_reg;
    assign ReadValid[gi] = valid_reg;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised register file with NREAD independent, registered read ports and one write port. It replaces the fixed 32-register, 64-bit combinational read path. Adds synchronous reset of storage, a hardwired zero register, same-cycle write-to-read bypass, per-port read enables with held outputs, and a valid flag per port. It sits between instruction decode and the execute stage of the CPU datapath.

## Interface
- WIDTH, default 64: data width of each register.
- DEPTH, default 32: number of registers; must be ≥ 2 and need not be a power of 2.
- NREAD, default 2: number of read ports.
- ZERO_REG, default DEPTH-1: index that always reads 0 and ignores writes.
- BYPASS, default 1: 1 means a same-cycle write is forwarded to reads of the same index; 0 means reads return the pre-write value.
- AW (localparam) = $clog2(DEPTH).
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising clk edge.
- RegWrite  in  1  write enable.
- WriteRegister  in  AW  write index.
- WriteData  in  WIDTH  write data.
- ReadEn  in  NREAD  per-port read request.
- ReadRegister  in  [NREAD][AW]  per-port read index.
- ReadData  out  [NREAD][WIDTH]  registered read data.
- ReadValid  out  NREAD  high for one cycle per accepted read.

## Operation
- Storage is DEPTH×WIDTH flops. Reset clears every entry, every ReadData and every ReadValid to 0.
- Write at the edge when RegWrite=1, reset=0, WriteRegister≠ZERO_REG and WriteRegister<DEPTH: entry[WriteRegister] ← WriteData.
  - Writes to ZERO_REG or to an out-of-range index are silently dropped.
- Read on port p at the edge when ReadEn[p]=1 and reset=0. ReadValid[p] ← 1, and ReadData[p] ← one of the following, in priority order:
  - 0 if ReadRegister[p]=ZERO_REG or ReadRegister[p]≥DEPTH.
  - WriteData if BYPASS=1, RegWrite=1 and WriteRegister=ReadRegister[p].
  - Otherwise entry[ReadRegister[p]] as it stood before the edge.
- When ReadEn[p]=0 and reset=0: ReadValid[p] ← 0 and ReadData[p] holds its previous value.
- Ports are fully independent:
  - Any number of ports may read the same index in the same cycle.
  - Every such port receives the identical value, bypass included.
- Reset has priority over write and read in the same cycle: no entry is written and no read is accepted.
- A read issued in the reset cycle is lost; ReadValid stays 0 for it.
- No internal state machine. The only state is storage plus the output registers.

## Timing
- Write latency: 1 edge. A read issued in the cycle after a write sees the new value regardless of BYPASS.
- Read latency: exactly 1 cycle. ReadData/ReadValid update at the edge that samples ReadEn and are stable for the whole following cycle.
- Throughput: one read per port per cycle plus one write per cycle, with no stalls or back-pressure.
- Same-cycle write and read to the same index:
  - BYPASS=1: returns the new value (WriteData).
  - BYPASS=0: returns the old value.
- No combinational path from any input to any output.

## Test plan
- Reset then read all indices on every port → every ReadData=0, ReadValid=1 one cycle after each ReadEn. Assert reset while ReadEn=1 → ReadValid=0 on the following cycle.
- Write 0xDEADBEEF_00000005 to reg 5. Next cycle read reg 5 on ports 0 and 1 → both ReadData=0xDEADBEEF_00000005 one cycle later.
- Write 0x1234 to ZERO_REG (31), then read reg 31 → 0. Write reg 3 with RegWrite=0 → reg 3 still reads its prior value.
- BYPASS=1: reg 7 holds 0xAA; in the same cycle write 0xBB to reg 7 and read reg 7 → ReadData=0xBB. Rerun with BYPASS=0 → 0xAA, and 0xBB on the next read.
- Read reg 2 (holds 0x22) with ReadEn=1, then three cycles of ReadEn=0 while reg 2 is rewritten to 0x33 → ReadData stays 0x22 with ReadValid=0.
- DEPTH=20, NREAD=3, WIDTH=16: read index 25 → 0. Write index 25 → no entry changes. Random write/read sequence against a scoreboard for 10k cycles → zero mismatches.
